// File: rtl/rvv_backend_alu_issue_pkg.sv
// ============================================================================
// Module : rvv_backend_alu_issue_pkg
// Brief  : Shared ALU reservation-station entry type and lane count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rvv_backend_alu_issue_pkg;

  localparam int NUM_ALU_UOP  = 2;
  localparam int ALU_RS_WIDTH = 40;

  typedef struct packed {
    logic [7:0]  rob_entry;
    logic [31:0] vs1_data;
  } ALU_RS_t;

endpackage

`default_nettype wire

// File: rtl/rvv_backend_alu_issue_slot.sv
// ============================================================================
// Module : rvv_backend_alu_issue_slot
// Brief  : One ALU lane issue register (valid + payload) with flush priority.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rvv_backend_alu_issue_slot
  import rvv_backend_alu_issue_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    load_i,
  input  ALU_RS_t load_data_i,
  input  logic    ready_i,
  input  logic    flush_i,
  output logic    valid_o,
  output ALU_RS_t data_o
);

  logic    valid_q, valid_d;
  ALU_RS_t data_q,  data_d;

  // Payload only moves on a load, so it stays stable while valid waits for ready.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = load_data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/rvv_backend_alu_issue.sv
// ============================================================================
// Module : rvv_backend_alu_issue
// Brief  : Pops up to two oldest RS uops per cycle and steers them, in order, to free ALU lanes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rvv_backend_alu_issue
  import rvv_backend_alu_issue_pkg::*;
#(
  parameter int NUM_LANE = NUM_ALU_UOP
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  ALU_RS_t [NUM_LANE-1:0]   alu_uop_rs2ex,
  input  logic                     fifo_empty_rs2ex,
  input  logic                     fifo_1left_to_empty_rs2ex,
  output logic    [NUM_LANE-1:0]   pop_ex2rs,
  input  logic                     trap_flush_rvv,
  output logic    [NUM_LANE-1:0]   alu_uop_valid_ex,
  output ALU_RS_t [NUM_LANE-1:0]   alu_uop_ex,
  input  logic    [NUM_LANE-1:0]   alu_uop_ready_ex
);

  logic    [1:0]          navail;
  logic    [1:0]          nfree;
  logic    [1:0]          npop;
  logic    [NUM_LANE-1:0] lane_free;
  logic    [NUM_LANE-1:0] lane_load;
  ALU_RS_t [NUM_LANE-1:0] lane_data;

  always_comb begin
    navail    = fifo_empty_rs2ex ? 2'd0 : (fifo_1left_to_empty_rs2ex ? 2'd1 : 2'd2);
    lane_free = ~alu_uop_valid_ex | alu_uop_ready_ex;
    nfree     = {1'b0, lane_free[0]} + {1'b0, lane_free[1]};
    if (!rst_n || trap_flush_rvv) begin
      npop = 2'd0;
    end else begin
      npop = (navail < nfree) ? navail : nfree;
    end
    pop_ex2rs = {npop == 2'd2, npop != 2'd0};

    // Oldest entry takes the lowest free lane; when lane0 is busy it lands on lane1.
    lane_load[0] = lane_free[0] & (npop != 2'd0);
    lane_load[1] = lane_free[1] & (lane_free[0] ? (npop == 2'd2) : (npop != 2'd0));
    lane_data[0] = alu_uop_rs2ex[0];
    lane_data[1] = lane_free[0] ? alu_uop_rs2ex[1] : alu_uop_rs2ex[0];
  end

  for (genvar k = 0; k < NUM_LANE; k++) begin : g_lane
    rvv_backend_alu_issue_slot u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (lane_load[k]),
      .load_data_i (lane_data[k]),
      .ready_i     (alu_uop_ready_ex[k]),
      .flush_i     (trap_flush_rvv),
      .valid_o     (alu_uop_valid_ex[k]),
      .data_o      (alu_uop_ex[k])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_rvv_backend_alu_issue.sv
// ============================================================================
// Module : tb_rvv_backend_alu_issue
// Brief  : Directed self-checking bench for the ALU issue stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rvv_backend_alu_issue;
  import rvv_backend_alu_issue_pkg::*;

  logic          clk;
  logic          rst_n;
  ALU_RS_t [1:0] rs;
  logic          empty;
  logic          one_left;
  logic    [1:0] pop;
  logic          flush;
  logic    [1:0] valid;
  ALU_RS_t [1:0] uop;
  logic    [1:0] ready;

  int n_tests;
  int n_fail;

  rvv_backend_alu_issue #(.NUM_LANE(2)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .alu_uop_rs2ex             (rs),
    .fifo_empty_rs2ex          (empty),
    .fifo_1left_to_empty_rs2ex (one_left),
    .pop_ex2rs                 (pop),
    .trap_flush_rvv            (flush),
    .alu_uop_valid_ex          (valid),
    .alu_uop_ex                (uop),
    .alu_uop_ready_ex          (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ALU_RS_t mk(input logic [7:0] tag);
    ALU_RS_t u;
    u.rob_entry = tag;
    u.vs1_data  = {4{tag}} ^ 32'h5A5A_0000;
    return u;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs on the falling edge, then check the combinational pop.
  task automatic drive(input logic rn, input logic e, input logic o, input ALU_RS_t r0,
                       input ALU_RS_t r1, input logic [1:0] rdy, input logic fl,
                       input string tag, input logic [1:0] exp_pop);
    @(negedge clk);
    rst_n = rn; empty = e; one_left = o; rs[0] = r0; rs[1] = r1; ready = rdy; flush = fl;
    #1;
    check({tag, ".pop"}, 64'(pop), 64'(exp_pop));
  endtask

  // After the rising edge, check registered lane state.
  task automatic after_edge(input string tag, input logic [1:0] exp_valid);
    @(posedge clk);
    #1;
    check({tag, ".valid"}, 64'(valid), 64'(exp_valid));
  endtask

  task automatic lane(input string tag, input int k, input ALU_RS_t exp);
    check(tag, 64'(uop[k]), 64'(exp));
  endtask

  localparam ALU_RS_t ZERO = '0;

  initial begin
    ALU_RS_t A, B, C, D, E, F, X;
    n_tests = 0; n_fail = 0;
    A = mk(8'hA1); B = mk(8'hB2); C = mk(8'hC3); D = mk(8'hD4);
    E = mk(8'hE5); F = mk(8'hF6); X = mk(8'h99);
    rst_n = 1'b0; empty = 1'b0; one_left = 1'b0; rs = '0; ready = 2'b11; flush = 1'b0;

    // Reset held 3 cycles with a non-empty RS
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, A, B, 2'b11, 1'b0, "rst", 2'b00);
      after_edge("rst", 2'b00);
    end
    lane("rst.lane0", 0, ZERO);
    lane("rst.lane1", 1, ZERO);

    // Streaming A..F with both ALUs ready
    drive(1'b1, 1'b0, 1'b0, A, B, 2'b11, 1'b0, "strAB", 2'b11);
    after_edge("strAB", 2'b11);
    lane("strAB.lane0", 0, A); lane("strAB.lane1", 1, B);
    drive(1'b1, 1'b0, 1'b0, C, D, 2'b11, 1'b0, "strCD", 2'b11);
    after_edge("strCD", 2'b11);
    lane("strCD.lane0", 0, C); lane("strCD.lane1", 1, D);
    drive(1'b1, 1'b0, 1'b0, E, F, 2'b11, 1'b0, "strEF", 2'b11);
    after_edge("strEF", 2'b11);
    lane("strEF.lane0", 0, E); lane("strEF.lane1", 1, F);

    // RS empty: lanes drain
    drive(1'b1, 1'b1, 1'b0, X, X, 2'b11, 1'b0, "empty", 2'b00);
    after_edge("empty", 2'b00);

    // Single entry
    drive(1'b1, 1'b0, 1'b1, A, X, 2'b11, 1'b0, "single", 2'b01);
    after_edge("single", 2'b01);
    lane("single.lane0", 0, A);

    // Back-pressure: lane0 stalls holding A, lane1 idle
    drive(1'b1, 1'b0, 1'b0, B, C, 2'b10, 1'b0, "bp1", 2'b01);
    after_edge("bp1", 2'b11);
    lane("bp1.lane0", 0, A); lane("bp1.lane1", 1, B);
    drive(1'b1, 1'b0, 1'b0, C, D, 2'b00, 1'b0, "bp2", 2'b00);
    after_edge("bp2", 2'b11);
    lane("bp2.lane0", 0, A); lane("bp2.lane1", 1, B);
    drive(1'b1, 1'b0, 1'b0, C, D, 2'b01, 1'b0, "bp3", 2'b01);
    after_edge("bp3", 2'b11);
    lane("bp3.lane0", 0, C); lane("bp3.lane1", 1, B);

    // Steering gap: lane0 stalled, lane1 accepts; oldest goes to lane1
    drive(1'b1, 1'b0, 1'b0, D, E, 2'b10, 1'b0, "gap", 2'b01);
    after_edge("gap", 2'b11);
    lane("gap.lane0", 0, C); lane("gap.lane1", 1, D);

    // Flush while both lanes valid and RS non-empty, then resume
    drive(1'b1, 1'b0, 1'b0, E, F, 2'b11, 1'b1, "flush", 2'b00);
    after_edge("flush", 2'b00);
    drive(1'b1, 1'b0, 1'b0, E, F, 2'b11, 1'b0, "resume", 2'b11);
    after_edge("resume", 2'b11);
    lane("resume.lane0", 0, E); lane("resume.lane1", 1, F);

    // Flush with stalled lanes still clears them
    drive(1'b1, 1'b0, 1'b0, A, B, 2'b00, 1'b1, "flstall", 2'b00);
    after_edge("flstall", 2'b00);
    drive(1'b1, 1'b0, 1'b0, A, B, 2'b00, 1'b0, "reload", 2'b11);
    after_edge("reload", 2'b11);
    lane("reload.lane0", 0, A); lane("reload.lane1", 1, B);

    // Reset mid-operation drops the slots
    drive(1'b0, 1'b0, 1'b0, C, D, 2'b00, 1'b0, "midrst", 2'b00);
    after_edge("midrst", 2'b00);
    lane("midrst.lane0", 0, ZERO); lane("midrst.lane1", 1, ZERO);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
